jtag_tap_ctrl: RTL
==================

Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1 TAP controller plus instruction register, directly upstream of the generic JTAG data registers.
- Tracks the 16-state TAP FSM from TMS and shifts, captures and updates the IR.
- Drives the decoded state strobes and `ir_reg` consumed by every data register instance.
- Muxes the serial TDO between IR shift data and the selected data register's serial output.

Parameters:
- IR_LEN, 4, instruction register width (≥2).
- IR_CAPTURE, 4'b0101, value loaded into the IR shift stage in Capture-IR; bits [1:0] must be 2'b01.
- IR_RESET_OPCODE, 4'b0001, instruction loaded into `ir_reg` on reset and in Test-Logic-Reset.

Ports:
- tck  input  1  TAP clock; all state changes on its rising edge.
- trst  input  1  reset, synchronous, active-high.
- tms  input  1  test mode select, sampled on the rising edge of tck.
- tdi  input  1  serial data in, sampled on the rising edge in Shift-IR.
- dr_tdo  input  1  serial out of the data register selected by `ir_reg` (muxed externally).
- tdo  output  1  serial data out.
- tdo_en  output  1  high while in Shift-IR or Shift-DR.
- state_tlr  output  1  FSM in Test-Logic-Reset.
- state_runidle  output  1  FSM in Run-Test/Idle.
- state_capturedr  output  1  FSM in Capture-DR.
- state_shiftdr  output  1  FSM in Shift-DR.
- state_updatedr  output  1  FSM in Update-DR.
- ir_reg  output  IR_LEN  current active instruction.
- ir_update  output  1  one-cycle pulse, registered, the cycle after `ir_reg` changes due to Update-IR.

Behaviour:
- Clocking and reset:
  - Single clock tck.
  - `trst`=1 at a rising edge forces state=TLR, `ir_reg`=IR_RESET_OPCODE, IR shift stage=0, `ir_update`=0.
  - `trst` overrides all other inputs, including a reset asserted mid-shift; the partial IR shift is discarded.
- State strobes:
  - Purely combinational decode of the registered state, so each strobe is valid for the whole cycle the FSM is in that state.
  - Data registers act on the edge that leaves the state.
  - After reset: `state_tlr`=1, all other strobes 0, `tdo`=0, `tdo_en`=0.
- FSM transitions (next state for TMS=0 / TMS=1):
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauseDR / UpdDR
  - PauseDR: PauseDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - CapIR: ShIR / Ex1IR
  - ShIR: ShIR / Ex1IR
  - Ex1IR: PauseIR / UpdIR
  - PauseIR: PauseIR / Ex2IR
  - Ex2IR: ShIR / UpdIR
  - UpdIR: RTI / SelDR
- TLR reachability: five consecutive TMS=1 edges reach TLR from any state.
- IR shift stage (IR_LEN bits):
  - In CapIR: loads IR_CAPTURE.
  - In ShIR: loads {tdi, shift[IR_LEN-1:1]}, LSB first out.
  - Otherwise holds.
- `ir_reg` updates:
  - In UpdIR: loads the shift stage and asserts `ir_update` the next cycle.
  - In TLR (every cycle there): reloads IR_RESET_OPCODE, with no `ir_update` pulse.
  - Otherwise `ir_reg` holds, so it is stable through all DR states.
- TDO output:
  - In ShIR: `tdo` = shift[0].
  - In ShDR: `tdo` = `dr_tdo`.
  - Otherwise `tdo`=0.
  - Combinational mux on the registered state, with no added latency.
- Latency: a first ShIR cycle presents IR_CAPTURE[0] on `tdo` before any tdi bit is consumed. An N-bit shift returns the N captured bits.

Decomposition:
- Package `jtag_pkg`:
  - `tap_state_t` enum of the 16 states, 4-bit encoding as listed above in order 0..15.
  - Constant TAP_RESET_TMS_CYCLES=5.
- Sub-module `jtag_tap_fsm`: state register plus next-state logic plus strobe decode.
- Top: IR shift/update, TDO mux, `ir_update` pulse.

Test Plan:
- Reset: assert `trst` 1 cycle with tms=0 → next cycle `state_tlr`=1, `ir_reg`=4'b0001, `tdo_en`=0; one tms=0 edge → `state_runidle`=1.
- TLR recovery: from ShDR, drive tms=1 for 5 edges → `state_tlr`=1.
- IR load:
  - Stimulus: RTI→SelDR→SelIR→CapIR→ShIR, shift tdi=0,1,0,1 LSB first with tms=1 on the 4th bit, then UpdIR.
  - Required response: `tdo` bits read 1,0,1,0 (IR_CAPTURE); `ir_reg`=4'b1010 after UpdIR; `ir_update` high exactly one cycle.
- DR path:
  - Stimulus: `ir_reg`=4'b1010, traverse CapDR, ShDR×8, Ex1DR, PauseDR×3, Ex2DR, ShDR×2, Ex1DR, UpdDR.
  - Required response: `state_capturedr`, `state_shiftdr`, `state_updatedr` assert on the exact cycles; `tdo` follows `dr_tdo` only in ShDR; `ir_reg` stays 4'b1010.
- Reset mid-IR-shift: after 2 ShIR bits, assert `trst` → TLR, `ir_reg`=4'b0001, no `ir_update` pulse.
- Full transition sweep: drive each state with tms=0 and tms=1 → next state matches the transition list for all 32 arcs.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP state encoding and constants for the JTAG TAP controller.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PAUSE_DR, TAP_EX2_DR,
    TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PAUSE_IR, TAP_EX2_IR,
    TAP_UPD_IR
  } tap_state_t;

  localparam int unsigned TAP_RESET_TMS_CYCLES = 5;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine with decoded state strobes.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       i_tck,
  input  logic       i_trst,
  input  logic       i_tms,
  output tap_state_t o_state,
  output logic       o_state_tlr,
  output logic       o_state_runidle,
  output logic       o_state_capturedr,
  output logic       o_state_shiftdr,
  output logic       o_state_updatedr
);

  tap_state_t r_state;
  tap_state_t w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      TAP_TLR:      w_next = i_tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      w_next = i_tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   w_next = i_tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   w_next = i_tms ? TAP_EX1_DR   : TAP_SH_DR;
      TAP_SH_DR:    w_next = i_tms ? TAP_EX1_DR   : TAP_SH_DR;
      TAP_EX1_DR:   w_next = i_tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: w_next = i_tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
      TAP_EX2_DR:   w_next = i_tms ? TAP_UPD_DR   : TAP_SH_DR;
      TAP_UPD_DR:   w_next = i_tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   w_next = i_tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   w_next = i_tms ? TAP_EX1_IR   : TAP_SH_IR;
      TAP_SH_IR:    w_next = i_tms ? TAP_EX1_IR   : TAP_SH_IR;
      TAP_EX1_IR:   w_next = i_tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: w_next = i_tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
      TAP_EX2_IR:   w_next = i_tms ? TAP_UPD_IR   : TAP_SH_IR;
      TAP_UPD_IR:   w_next = i_tms ? TAP_SEL_DR   : TAP_RTI;
      default:      w_next = TAP_TLR;
    endcase
  end

  always_ff @(posedge i_tck) begin
    if (i_trst) begin
      r_state <= TAP_TLR;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes decode the registered state, so each is valid for the whole cycle.
  always_comb begin
    o_state           = r_state;
    o_state_tlr       = (r_state == TAP_TLR);
    o_state_runidle   = (r_state == TAP_RTI);
    o_state_capturedr = (r_state == TAP_CAP_DR);
    o_state_shiftdr   = (r_state == TAP_SH_DR);
    o_state_updatedr  = (r_state == TAP_UPD_DR);
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: instruction register capture/shift/update and TDO mux.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned        IR_LEN          = 4,
  parameter logic [IR_LEN-1:0]  IR_CAPTURE      = 4'b0101,
  parameter logic [IR_LEN-1:0]  IR_RESET_OPCODE = 4'b0001
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              tms,
  input  logic              tdi,
  input  logic              dr_tdo,
  output logic              tdo,
  output logic              tdo_en,
  output logic              state_tlr,
  output logic              state_runidle,
  output logic              state_capturedr,
  output logic              state_shiftdr,
  output logic              state_updatedr,
  output logic [IR_LEN-1:0] ir_reg,
  output logic              ir_update
);

  tap_state_t        w_state;
  logic [IR_LEN-1:0] r_ir_shift;
  logic [IR_LEN-1:0] r_ir_reg;
  logic              r_ir_update;

  jtag_tap_fsm u_fsm (
    .i_tck             (tck),
    .i_trst            (trst),
    .i_tms             (tms),
    .o_state           (w_state),
    .o_state_tlr       (state_tlr),
    .o_state_runidle   (state_runidle),
    .o_state_capturedr (state_capturedr),
    .o_state_shiftdr   (state_shiftdr),
    .o_state_updatedr  (state_updatedr)
  );

  // Reset discards any partial IR shift; TLR keeps reloading the reset opcode without a pulse.
  always_ff @(posedge tck) begin
    if (trst) begin
      r_ir_shift  <= '0;
      r_ir_reg    <= IR_RESET_OPCODE;
      r_ir_update <= 1'b0;
    end else begin
      r_ir_update <= (w_state == TAP_UPD_IR);
      if (w_state == TAP_CAP_IR) begin
        r_ir_shift <= IR_CAPTURE;
      end else if (w_state == TAP_SH_IR) begin
        r_ir_shift <= {tdi, r_ir_shift[IR_LEN-1:1]};
      end
      if (w_state == TAP_UPD_IR) begin
        r_ir_reg <= r_ir_shift;
      end else if (w_state == TAP_TLR) begin
        r_ir_reg <= IR_RESET_OPCODE;
      end
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (w_state == TAP_SH_IR) begin
      tdo = r_ir_shift[0];
    end else if (w_state == TAP_SH_DR) begin
      tdo = dr_tdo;
    end
    tdo_en    = (w_state == TAP_SH_IR) || (w_state == TAP_SH_DR);
    ir_reg    = r_ir_reg;
    ir_update = r_ir_update;
  end

endmodule
